vga_line_buffer: RTL and testbench
==================================

VGA_LINE_BUFFER -- requirements
Module: vga_line_buffer

Interface
REQ-001 SHALL be clocked by i_VGA_CLK; reset i_rst_n is synchronous and active-low.
REQ-002 i_VGA_CLK  in  1  pixel clock (25.175 MHz, 640x480@60).
REQ-003 i_rst_n  in  1  synchronous active-low reset.
REQ-004 i_de, i_hsync, i_vsync  in  1 each  timing-generator outputs for the current pixel.
REQ-005 i_Sx, i_Sy  in  10 each  current pixel column/row, total-frame coordinates.
REQ-006 o_line_req  out  1  one-cycle pulse requesting a line fetch.
REQ-007 o_line_num  out  10  requested line index, held stable until the next o_line_req.
REQ-008 i_px_valid  in  1, i_px_data  in  24 ({R,G,B}), o_px_ready  out  1  pixel stream; a pixel transfers when valid && ready.
REQ-009 o_VGA_R, o_VGA_G, o_VGA_B  out  8 each  pixel colour.
REQ-010 o_de, o_hsync, o_vsync  out  1 each  timing delayed to match colour.
REQ-011 o_underflow  out  1  sticky flag: a line was not complete at display time.

Function
REQ-012 SHALL hold two 640x24 banks, one read (display) and one write (fill), ping-pong.
REQ-013 Line boundary := i_Sx == H_TOTAL-1 (799).
REQ-014 Swap event := boundary where (i_Sy+1) mod 525 < 480; request event := boundary where (i_Sy+2) mod 525 < 480.
REQ-015 On a boundary with both events, swap SHALL take effect first; the request then targets the newly freed bank.
REQ-016 Request: o_line_req high one cycle after the boundary, o_line_num = (i_Sy+2) mod 525; writer enters FILL with write address 0.
REQ-017 Writer FSM states IDLE, FILL, DONE: IDLE->FILL on request; FILL->DONE on the 640th transfer; DONE->IDLE on swap.
REQ-018 o_px_ready SHALL be high only in FILL; in IDLE/DONE, i_px_valid is ignored and no write occurs.
REQ-019 On swap with writer in DONE: banks exchange and the new read bank is marked valid.
REQ-020 On swap with writer in IDLE or FILL: no exchange, read bank marked invalid, o_underflow set, partial fill discarded, write address reset to 0.
REQ-021 Colour SHALL be 0 when the delayed de is 0 or the read bank is invalid; otherwise it is the read-bank entry at address i_Sx.
REQ-022 Latency SHALL be exactly 2 cycles from (i_Sx, i_Sy, i_de) to colour; o_de, o_hsync and o_vsync SHALL be delayed by 2 cycles to match.
REQ-023 Write address SHALL not exceed 639; no wrap-around within a line.
REQ-024 o_underflow SHALL clear only on reset.

Reset
REQ-025 On reset: colours 0, o_de 0, o_hsync/o_vsync 1 (inactive), o_line_req 0, o_line_num 0, o_px_ready 0, o_underflow 0.
REQ-026 On reset: writer IDLE, both banks invalid, read bank = bank 0, delay pipeline flushed.
REQ-027 Reset asserted mid-FILL SHALL abort the fill with no further writes; RAM contents need not clear.

Structure
REQ-028 Shared package vga_pkg SHALL hold H_ACTIVE=640, H_TOTAL=800, V_ACTIVE=480, V_TOTAL=525, rgb_t (packed 3x8), and the writer state enum.
REQ-029 One sub-module vga_line_ram: simple dual-port 1280x24 RAM with synchronous read, bank selected by address MSB.

Verification
REQ-030 Reset, then drive the frame from (799,523); source supplies 640 ramp pixels per request immediately -> o_line_req with o_line_num=0 at the boundary ending line 523; line 0 displays ramp values 2 cycles after each i_Sx; o_underflow stays 0.
REQ-031 Source delivers only 639 pixels for line 5 -> line 5 displays black, o_underflow=1; line 6 displays correctly.
REQ-032 i_px_valid held high while o_px_ready=0 (DONE) -> no RAM write; displayed line unchanged.
REQ-033 During the boundary ending line 478 -> swap occurs, no request (line 480 inactive), writer stays IDLE through vertical blanking until the boundary ending line 523.
REQ-034 Reset pulsed after 300 pixels of a fill -> o_px_ready=0 the next cycle, all outputs at reset values, normal operation resumes on the next request event.
REQ-035 i_hsync, i_vsync and i_de toggled during blanking -> o_hsync, o_vsync and o_de reproduce them exactly 2 cycles later, with colour 0 throughout.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, pixel type and line-writer state encoding.
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;
    localparam int DATA_W   = 24;
    localparam int COL_W    = 10;
    localparam int ADDR_W   = COL_W + 1;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_FILL,
        WR_DONE
    } wr_state_t;

    // Row index `adv` lines ahead of sy, wrapped at the frame height (adv <= 3).
    function automatic logic [COL_W-1:0] line_ahead(input logic [COL_W-1:0] sy,
                                                    input logic [1:0] adv);
        logic [COL_W:0] sum;
        sum = {1'b0, sy} + {{(COL_W-1){1'b0}}, adv};
        if (sum >= (COL_W+1)'(V_TOTAL))
            sum = sum - (COL_W+1)'(V_TOTAL);
        return sum[COL_W-1:0];
    endfunction
endpackage

// File: rtl/vga_line_ram.sv
// Two 640-entry line banks in one simple dual-port RAM; address MSB picks the bank.
module vga_line_ram
    import vga_pkg::*;
#(
    parameter int DATA_W = 24
) (
    input  logic              i_VGA_CLK,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [2][H_ACTIVE];

    always_ff @(posedge i_VGA_CLK) begin
        if (wr_en)
            mem[wr_addr[ADDR_W-1]][wr_addr[COL_W-1:0]] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr[ADDR_W-1]][rd_addr[COL_W-1:0]];
    end
endmodule

// File: rtl/vga_line_buffer.sv
// Ping-pong line buffer: fills one bank from a pixel stream while the other is displayed.
module vga_line_buffer
    import vga_pkg::*;
(
    input  logic             i_VGA_CLK,
    input  logic             i_rst_n,
    input  logic             i_de,
    input  logic             i_hsync,
    input  logic             i_vsync,
    input  logic [COL_W-1:0] i_Sx,
    input  logic [COL_W-1:0] i_Sy,
    output logic             o_line_req,
    output logic [COL_W-1:0] o_line_num,
    input  logic             i_px_valid,
    input  logic [DATA_W-1:0] i_px_data,
    output logic             o_px_ready,
    output logic [7:0]       o_VGA_R,
    output logic [7:0]       o_VGA_G,
    output logic [7:0]       o_VGA_B,
    output logic             o_de,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_underflow
);
    wr_state_t        wr_state;
    logic [COL_W-1:0] wr_col;
    logic             rd_bank;
    logic             rd_valid;
    logic             boundary, swap_evt, req_evt, xfer, wr_en, col_ok;
    rgb_t             rd_px;
    logic             de_p0, hs_p0, vs_p0, vld_p0;

    assign boundary = (i_Sx == COL_W'(H_TOTAL - 1));
    assign swap_evt = boundary && (line_ahead(i_Sy, 2'd1) < COL_W'(V_ACTIVE));
    assign req_evt  = boundary && (line_ahead(i_Sy, 2'd2) < COL_W'(V_ACTIVE));
    assign xfer     = i_px_valid && o_px_ready;
    // A transfer coinciding with a swap/request belongs to a fill that is being discarded.
    assign wr_en    = xfer && i_rst_n && !swap_evt && !req_evt;
    assign col_ok   = (i_Sx < COL_W'(H_ACTIVE));

    vga_line_ram #(.DATA_W(DATA_W)) u_ram (
        .i_VGA_CLK (i_VGA_CLK),
        .wr_en     (wr_en),
        .wr_addr   ({~rd_bank, wr_col}),
        .wr_data   (i_px_data),
        .rd_en     (col_ok),
        .rd_addr   ({rd_bank, i_Sx}),
        .rd_data   (rd_px)
    );

    // Writer FSM; swap is resolved before the request so a request fills the freed bank.
    always_ff @(posedge i_VGA_CLK) begin
        if (!i_rst_n) begin
            wr_state    <= WR_IDLE;
            wr_col      <= '0;
            o_px_ready  <= 1'b0;
            rd_bank     <= 1'b0;
            rd_valid    <= 1'b0;
            o_underflow <= 1'b0;
            o_line_req  <= 1'b0;
            o_line_num  <= '0;
        end else begin
            o_line_req <= 1'b0;
            if (swap_evt || req_evt) begin
                if (swap_evt) begin
                    if (wr_state == WR_DONE) begin
                        rd_bank  <= ~rd_bank;
                        rd_valid <= 1'b1;
                    end else begin
                        rd_valid    <= 1'b0;
                        o_underflow <= 1'b1;
                    end
                    wr_state   <= WR_IDLE;
                    o_px_ready <= 1'b0;
                    wr_col     <= '0;
                end
                if (req_evt) begin
                    wr_state   <= WR_FILL;
                    o_px_ready <= 1'b1;
                    wr_col     <= '0;
                    o_line_req <= 1'b1;
                    o_line_num <= line_ahead(i_Sy, 2'd2);
                end
            end else if (xfer) begin
                if (wr_col == COL_W'(H_ACTIVE - 1)) begin
                    wr_state   <= WR_DONE;
                    o_px_ready <= 1'b0;
                end else begin
                    wr_col <= wr_col + 1'b1;
                end
            end
        end
    end

    // p0: RAM read in flight, timing and gating registered alongside
    // p1: colour muxed and driven with matching timing
    always_ff @(posedge i_VGA_CLK) begin
        if (!i_rst_n) begin
            de_p0   <= 1'b0;
            hs_p0   <= 1'b1;
            vs_p0   <= 1'b1;
            vld_p0  <= 1'b0;
            o_de    <= 1'b0;
            o_hsync <= 1'b1;
            o_vsync <= 1'b1;
            o_VGA_R <= '0;
            o_VGA_G <= '0;
            o_VGA_B <= '0;
        end else begin
            de_p0   <= i_de;
            hs_p0   <= i_hsync;
            vs_p0   <= i_vsync;
            vld_p0  <= rd_valid && i_de && col_ok;
            o_de    <= de_p0;
            o_hsync <= hs_p0;
            o_vsync <= vs_p0;
            if (vld_p0) begin
                o_VGA_R <= rd_px.r;
                o_VGA_G <= rd_px.g;
                o_VGA_B <= rd_px.b;
            end else begin
                o_VGA_R <= '0;
                o_VGA_G <= '0;
                o_VGA_B <= '0;
            end
        end
    end
endmodule

// File: tb/tb_vga_line_buffer.sv
// Bench for vga_line_buffer: reset/latency vector table, then frame-driven random traffic vs a line-level model.
module tb_vga_line_buffer;
    logic        i_VGA_CLK = 1'b0;
    logic        i_rst_n, i_de, i_hsync, i_vsync;
    logic [9:0]  i_Sx, i_Sy;
    logic        o_line_req;
    logic [9:0]  o_line_num;
    logic        i_px_valid;
    logic [23:0] i_px_data;
    logic        o_px_ready;
    logic [7:0]  o_VGA_R, o_VGA_G, o_VGA_B;
    logic        o_de, o_hsync, o_vsync, o_underflow;

    int total = 0;
    int bad   = 0;

    always #20 i_VGA_CLK = ~i_VGA_CLK;

    vga_line_buffer dut (
        .i_VGA_CLK  (i_VGA_CLK),
        .i_rst_n    (i_rst_n),
        .i_de       (i_de),
        .i_hsync    (i_hsync),
        .i_vsync    (i_vsync),
        .i_Sx       (i_Sx),
        .i_Sy       (i_Sy),
        .o_line_req (o_line_req),
        .o_line_num (o_line_num),
        .i_px_valid (i_px_valid),
        .i_px_data  (i_px_data),
        .o_px_ready (o_px_ready),
        .o_VGA_R    (o_VGA_R),
        .o_VGA_G    (o_VGA_G),
        .o_VGA_B    (o_VGA_B),
        .o_de       (o_de),
        .o_hsync    (o_hsync),
        .o_vsync    (o_vsync),
        .o_underflow(o_underflow)
    );

    // ---------------- line-level reference model ----------------
    typedef struct { logic de; logic hs; logic vs; logic [23:0] rgb; } out_t;
    logic [23:0] disp_buf [640];
    logic [23:0] fill_buf [640];
    bit   disp_valid, fill_on, m_under, m_req;
    int   fill_cnt, m_num;
    out_t m_pipe, m_out;
    int   pipe_sx, pipe_sy, out_sx, out_sy;

    function automatic void model_step();
        out_t nxt;
        bit   sw, rq;
        int   sx, sy;
        sx = int'(i_Sx);
        sy = int'(i_Sy);
        if (!i_rst_n) begin
            disp_valid = 0; fill_on = 0; fill_cnt = 0; m_under = 0; m_req = 0; m_num = 0;
            m_out  = '{1'b0, 1'b1, 1'b1, 24'h0};
            m_pipe = '{1'b0, 1'b1, 1'b1, 24'h0};
            pipe_sx = 800; pipe_sy = 999; out_sx = 800; out_sy = 999;
            return;
        end
        nxt.de  = i_de;
        nxt.hs  = i_hsync;
        nxt.vs  = i_vsync;
        nxt.rgb = (i_de && sx < 640 && disp_valid) ? disp_buf[sx] : 24'h0;
        m_out = m_pipe; out_sx = pipe_sx; out_sy = pipe_sy;
        m_pipe = nxt;   pipe_sx = sx;     pipe_sy = sy;
        m_req = 0;
        sw = (sx == 799) && (((sy + 1) % 525) < 480);
        rq = (sx == 799) && (((sy + 2) % 525) < 480);
        if (sw || rq) begin
            if (sw) begin
                if (fill_on && fill_cnt == 640) begin
                    disp_buf   = fill_buf;
                    disp_valid = 1;
                end else begin
                    disp_valid = 0;
                    m_under    = 1;
                end
                fill_on = 0;
            end
            if (rq) begin
                fill_on = 1; fill_cnt = 0; m_req = 1; m_num = (sy + 2) % 525;
            end
        end else if (i_px_valid && fill_on && fill_cnt < 640) begin
            fill_buf[fill_cnt] = i_px_data;
            fill_cnt++;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus source state ----------------
    int src_line = -1;
    int src_idx  = 0;
    bit arm_rst  = 0;
    bit rst_prev = 0;

    task automatic tick(input int sx, input int sy);
        int limit;
        if (o_line_req) begin
            src_line = int'(o_line_num);
            src_idx  = 0;
        end
        i_Sx    = 10'(sx);
        i_Sy    = 10'(sy);
        i_de    = (sx < 640 && sy < 480) || (sx >= 640 && $urandom_range(0, 1) == 1);
        i_hsync = $urandom_range(0, 1) == 1;
        i_vsync = $urandom_range(0, 1) == 1;
        if (arm_rst && src_line == 3 && src_idx >= 300 && o_px_ready) begin
            i_rst_n = 1'b0;
            arm_rst = 0;
        end else begin
            i_rst_n = 1'b1;
        end
        limit = (src_line == 5) ? 639 : 640;
        if (src_idx < limit) i_px_valid = ($urandom_range(0, 7) != 0);
        else                 i_px_valid = (src_line == 2);
        i_px_data = (src_line == 0) ? 24'(src_idx) : 24'($urandom);
        @(negedge i_VGA_CLK);
        chk("de",        o_de,        m_out.de);
        chk("hsync",     o_hsync,     m_out.hs);
        chk("vsync",     o_vsync,     m_out.vs);
        chk("rgb",       {o_VGA_R, o_VGA_G, o_VGA_B}, m_out.rgb);
        chk("line_req",  o_line_req,  m_req);
        chk("line_num",  o_line_num,  m_num);
        chk("px_ready",  o_px_ready,  fill_on && fill_cnt < 640);
        chk("underflow", o_underflow, m_under);
        if (out_sy == 0 && out_sx < 640 && m_out.de)
            chk("ramp_line0", {o_VGA_R, o_VGA_G, o_VGA_B}, 32'(out_sx));
        if (rst_prev) begin
            chk("rst_ready", o_px_ready, 0);
            chk("rst_under", o_underflow, 0);
            chk("rst_num",   o_line_num, 0);
            chk("rst_sync",  {o_de, o_hsync, o_vsync}, 3'b011);
        end
        rst_prev = !i_rst_n;
        if (i_px_valid && o_px_ready && i_rst_n) src_idx++;
        @(posedge i_VGA_CLK);
        model_step();
        #1;
    endtask

    task automatic run_line(input int sy);
        for (int x = 0; x < 800; x++) tick(x, sy);
    endtask

    // ---------------- reset / latency vector table ----------------
    typedef struct { logic rst_n; logic de; logic hs; logic vs; logic e_de; logic e_hs; logic e_vs; } vec_t;
    vec_t vecs [12];

    initial begin
        vecs = '{
            '{1'b0, 1'b1, 1'b0, 1'b0,  1'b0, 1'b1, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b1,  1'b0, 1'b1, 1'b1},
            '{1'b1, 1'b0, 1'b1, 1'b0,  1'b0, 1'b1, 1'b1},
            '{1'b1, 1'b1, 1'b1, 1'b1,  1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 1'b1, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 1'b1,  1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b1, 1'b0,  1'b0, 1'b1, 1'b1},
            '{1'b1, 1'b0, 1'b0, 1'b1,  1'b0, 1'b1, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b1,  1'b1, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b1},
            '{1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b1}
        };
        i_rst_n = 1'b0; i_de = 1'b0; i_hsync = 1'b1; i_vsync = 1'b1;
        i_Sx = 10'd700; i_Sy = 10'd500; i_px_valid = 1'b0; i_px_data = '0;
        repeat (2) begin
            @(posedge i_VGA_CLK);
            model_step();
            #1;
        end

        for (int i = 0; i < 12; i++) begin
            i_rst_n = vecs[i].rst_n;
            i_de    = vecs[i].de;
            i_hsync = vecs[i].hs;
            i_vsync = vecs[i].vs;
            @(negedge i_VGA_CLK);
            chk("vec_de",    o_de,    vecs[i].e_de);
            chk("vec_hsync", o_hsync, vecs[i].e_hs);
            chk("vec_vsync", o_vsync, vecs[i].e_vs);
            chk("vec_rgb",   {o_VGA_R, o_VGA_G, o_VGA_B}, 0);
            chk("vec_req",   {o_line_req, o_px_ready, o_underflow}, 0);
            chk("vec_num",   o_line_num, 0);
            @(posedge i_VGA_CLK);
            model_step();
            #1;
        end

        // First request comes from the boundary ending line 523.
        tick(799, 523);
        chk("req_after_523", o_line_req, 1);
        chk("num_after_523", o_line_num, 0);
        run_line(524);
        for (int l = 0; l <= 7; l++) run_line(l);
        chk("underflow_sticky", o_underflow, 1);

        // Into vertical blanking: last swap at line 478, writer idles until 523.
        for (int l = 476; l <= 478; l++) run_line(l);
        chk("no_req_after_478", o_line_req, 0);
        chk("idle_after_478",   o_px_ready, 0);
        for (int l = 479; l <= 481; l++) run_line(l);
        run_line(522);
        chk("idle_before_523", o_px_ready, 0);
        run_line(523);
        chk("req_again_523", {o_line_req, o_line_num}, {1'b1, 10'd0});
        run_line(524);
        run_line(0);
        run_line(1);

        // Reset pulse partway through the fill for line 3, then recovery.
        arm_rst = 1;
        for (int l = 2; l <= 6; l++) run_line(l);
        chk("rst_was_pulsed", arm_rst, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
